// File: rtl/park_dir_decoder.sv
// park_dir_decoder: gate-lane direction decoder for the parking counter.
// Each raw beam is synchronised and debounced. The debounced pair {db_a, db_b} then
// drives a passage-tracking FSM that emits one-cycle entry/exit/fault pulses.
// Optional feature macro: PARK_DIR_TIMEOUT_EN. When defined, a passage that takes
// longer than TIMEOUT_CYCLES is aborted with a fault.
module park_dir_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000
) (
  input  logic clk,
  input  logic reset,
  input  logic beam_a,
  input  logic beam_b,
  output logic entry_pulse,
  output logic exit_pulse,
  output logic fault_pulse,
  output logic busy
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] DbMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInA,
    StInAb,
    StInB,
    StOutB,
    StOutAb,
    StOutA,
    StWaitClr
  } state_e;

  // Bit 1 is beam A and bit 0 is beam B, so db_q is directly the {db_a, db_b} pair.
  logic [1:0]      raw;
  logic [1:0]      meta_q, sync_q, db_q;
  logic [CntW-1:0] cnt_q [2];

  state_e state_q, state_d;
  logic   entry_d, exit_d, fault_d;
  logic   entry_q, exit_q, fault_q, busy_q;
  logic   tmo_hit;

  assign raw = {beam_a, beam_b};

  // Two-flop synchroniser and per-beam debounce counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q   <= '0;
      sync_q   <= '0;
      db_q     <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DbMax) begin
          db_q[i]  <= sync_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end
      end
    end
  end

`ifdef PARK_DIR_TIMEOUT_EN
  localparam int unsigned TCntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCntW-1:0] TmoMax = TCntW'(TIMEOUT_CYCLES - 1);

  logic [TCntW-1:0] tcnt_q;
  logic             in_passage;

  assign in_passage = (state_q != StIdle) && (state_q != StWaitClr);
  assign tmo_hit    = in_passage && (tcnt_q == TmoMax);

  // Passage duration counter; idle and wait-for-clear states hold it at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt_q <= '0;
    end else if (!in_passage) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_q + TCntW'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  // Next-state decode of the debounced pair; the pulses are decided with the transition.
  always_comb begin
    state_d = state_q;
    entry_d = 1'b0;
    exit_d  = 1'b0;
    fault_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        case (db_q)
          2'b10:   state_d = StInA;
          2'b01:   state_d = StOutB;
          2'b11:   begin state_d = StWaitClr; fault_d = 1'b1; end
          default: ;
        endcase
      end
      StInA: begin
        case (db_q)
          2'b11:   state_d = StInAb;
          2'b00:   state_d = StIdle;
          2'b01:   begin state_d = StWaitClr; fault_d = 1'b1; end
          default: ;
        endcase
      end
      StInAb: begin
        case (db_q)
          2'b01:   state_d = StInB;
          2'b10:   state_d = StInA;
          2'b00:   begin state_d = StWaitClr; fault_d = 1'b1; end
          default: ;
        endcase
      end
      StInB: begin
        case (db_q)
          2'b00:   begin state_d = StIdle; entry_d = 1'b1; end
          2'b11:   state_d = StInAb;
          2'b10:   begin state_d = StWaitClr; fault_d = 1'b1; end
          default: ;
        endcase
      end
      StOutB: begin
        case (db_q)
          2'b11:   state_d = StOutAb;
          2'b00:   state_d = StIdle;
          2'b10:   begin state_d = StWaitClr; fault_d = 1'b1; end
          default: ;
        endcase
      end
      StOutAb: begin
        case (db_q)
          2'b10:   state_d = StOutA;
          2'b01:   state_d = StOutB;
          2'b00:   begin state_d = StWaitClr; fault_d = 1'b1; end
          default: ;
        endcase
      end
      StOutA: begin
        case (db_q)
          2'b00:   begin state_d = StIdle; exit_d = 1'b1; end
          2'b11:   state_d = StOutAb;
          2'b01:   begin state_d = StWaitClr; fault_d = 1'b1; end
          default: ;
        endcase
      end
      StWaitClr: begin
        if (db_q == 2'b00) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Timeout overrides whatever the sequence decode chose this cycle.
    if (tmo_hit) begin
      state_d = StWaitClr;
      entry_d = 1'b0;
      exit_d  = 1'b0;
      fault_d = 1'b1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      entry_q <= 1'b0;
      exit_q  <= 1'b0;
      fault_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      exit_q  <= exit_d;
      fault_q <= fault_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  assign entry_pulse = entry_q;
  assign exit_pulse  = exit_q;
  assign fault_pulse = fault_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_park_dir_decoder.sv
// Directed bench for park_dir_decoder with DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=50.
module tb_park_dir_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic beam_a = 1'b0;
  logic beam_b = 1'b0;
  logic entry_pulse, exit_pulse, fault_pulse, busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_entry  = 0;
  int n_exit   = 0;
  int n_fault  = 0;
  int n_multi  = 0;
  int b_entry, b_exit, b_fault;

  park_dir_decoder #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .beam_a     (beam_a),
    .beam_b     (beam_b),
    .entry_pulse(entry_pulse),
    .exit_pulse (exit_pulse),
    .fault_pulse(fault_pulse),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Pulse tally, sampled on the falling edge away from register updates.
  always @(negedge clk) begin
    if (entry_pulse) n_entry++;
    if (exit_pulse)  n_exit++;
    if (fault_pulse) n_fault++;
    if (int'(entry_pulse) + int'(exit_pulse) + int'(fault_pulse) > 1) n_multi++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive a beam pair at a falling edge and hold it for n cycles.
  task automatic hold(input logic a, input logic b, input int n);
    beam_a = a;
    beam_b = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    @(negedge clk);
    b_entry = n_entry;
    b_exit  = n_exit;
    b_fault = n_fault;
  endtask

  task automatic check_deltas(input string tag, input int de, input int dx, input int df);
    check({tag, " entry"}, n_entry - b_entry, de);
    check({tag, " exit"},  n_exit - b_exit,   dx);
    check({tag, " fault"}, n_fault - b_fault, df);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst entry", int'(entry_pulse), 0);
    check("rst exit",  int'(exit_pulse),  0);
    check("rst fault", int'(fault_pulse), 0);
    check("rst busy",  int'(busy),        0);
    reset = 1'b0;
    hold(1'b0, 1'b0, 5);

    // Entry with latency measured from the final raw edge
    snap();
    hold(1'b1, 1'b0, 10);
    check("entry busy in_a", int'(busy), 1);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 6);
    check("entry pulse early", int'(entry_pulse), 0);
    check("entry busy early",  int'(busy),        1);
    @(negedge clk);
    check("entry pulse at 7", int'(entry_pulse), 1);
    check("entry busy at 7",  int'(busy),        0);
    @(negedge clk);
    check("entry pulse width", int'(entry_pulse), 0);
    hold(1'b0, 1'b0, 5);
    check_deltas("entry", 1, 0, 0);

    // Exit
    snap();
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 10);
    check_deltas("exit", 0, 1, 0);
    check("exit busy", int'(busy), 0);

    // Entry backed out: A, AB, A, clear
    snap();
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b1, 1'b0, 10);
    check("backup busy", int'(busy), 1);
    hold(1'b0, 1'b0, 10);
    check_deltas("backup", 0, 0, 0);
    check("backup busy end", int'(busy), 0);

    // Two-cycle glitch on beam A while idle
    snap();
    hold(1'b1, 1'b0, 2);
    hold(1'b0, 1'b0, 3);
    check("glitch busy mid", int'(busy), 0);
    hold(1'b0, 1'b0, 7);
    check_deltas("glitch", 0, 0, 0);
    check("glitch busy", int'(busy), 0);

    // Both beams rise together: fault, then wait for full clear
    snap();
    hold(1'b1, 1'b1, 10);
    check_deltas("both", 0, 0, 1);
    check("both busy", int'(busy), 1);
    hold(1'b0, 1'b1, 10);
    check("both wait busy", int'(busy), 1);
    hold(1'b0, 1'b0, 10);
    check("both clr busy", int'(busy), 0);
    check_deltas("both clr", 0, 0, 1);

    // Reset during IN_AB drops the passage
    snap();
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    check("mid busy", int'(busy), 1);
    beam_a = 1'b0;
    beam_b = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    check("mid rst busy",  int'(busy),        0);
    check("mid rst entry", int'(entry_pulse), 0);
    check("mid rst fault", int'(fault_pulse), 0);
    @(negedge clk);
    reset = 1'b0;
    hold(1'b0, 1'b0, 15);
    check_deltas("mid rst", 0, 0, 0);
    check("mid rst busy after", int'(busy), 0);
    snap();
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 10);
    check_deltas("post rst exit", 0, 1, 0);

`ifdef PARK_DIR_TIMEOUT_EN
    // IN_A entered 7 edges after the raw edge; timeout fault 50 edges later
    snap();
    hold(1'b1, 1'b0, 56);
    check("tmo pulse early", int'(fault_pulse), 0);
    @(negedge clk);
    check("tmo pulse", int'(fault_pulse), 1);
    check("tmo busy",  int'(busy),        1);
    hold(1'b1, 1'b0, 3);
    hold(1'b0, 1'b0, 15);
    check_deltas("tmo", 0, 0, 1);
    check("tmo busy end", int'(busy), 0);
`else
    // Without timeout a long hold is harmless and the entry still completes
    snap();
    hold(1'b1, 1'b0, 60);
    check("long busy", int'(busy), 1);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 10);
    check_deltas("long entry", 1, 0, 0);
`endif

    check("exclusive pulses", n_multi, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
